// File: rtl/uart_rx_word_packer.sv
// 8N1 UART receiver that packs four bytes (first byte in [7:0]) into a 32-bit word
// behind a valid/ready handshake. Define UART_RX_PARITY_EN for 8E1 frames.
module uart_rx_word_packer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] data_out,
  output logic        valid,
  input  logic        ready,
  output logic [1:0]  byte_cnt,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TO_LIMIT > 0) ? TO_LIMIT - 1 : 0);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q;
  logic              rx_meta_q;
  logic              rx_sync_q;
  logic [CNT_W-1:0]  clk_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [23:0]       pack_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic              bit_done_d;
  logic              byte_ok_d;
  logic [31:0]       word_d;

  assign bit_done_d = (clk_cnt_q == BIT_LAST);
  assign word_d     = {shift_q, pack_q};

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign byte_ok_d = rx_sync_q & ~parity_err_q;
`else
  assign byte_ok_d = rx_sync_q;
`endif

  // Receive FSM, packing and output handshake share one register block so every
  // output is a flop; the load of a new word overrides the consume-clear of valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pack_q      <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      to_cnt_q    <= '0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (valid_q && ready) valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (!rx_sync_q) begin
            state_q  <= S_START;
            to_cnt_q <= '0;
          end else if (TIMEOUT_BITS > 0 && byte_cnt_q != 2'd0) begin
            // A stalled partial word is abandoned after the idle timeout.
            if (to_cnt_q == TO_LAST) begin
              byte_cnt_q <= '0;
              to_cnt_q   <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end else begin
            to_cnt_q <= '0;
          end
        end

        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done_d) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_done_d) begin
            clk_cnt_q    <= '0;
            parity_err_q <= ^{rx_sync_q, shift_q};
            state_q      <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_done_d) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
            if (byte_ok_d) begin
              if (byte_cnt_q == 2'd3) begin
                if (!valid_q || ready) begin
                  data_q  <= word_d;
                  valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                pack_q[8*byte_cnt_q +: 8] <= shift_q;
              end
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign byte_cnt  = byte_cnt_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: framing, packing, overrun, glitch,
// timeout and mid-frame reset, with pulse counters sampled on the falling edge.
module tb_uart_rx_word_packer;

  localparam int CPB = 16;

  logic        clk;
  logic        rst;
  logic        uart_rx;
  logic [31:0] data_out;
  logic        valid;
  logic        ready;
  logic [1:0]  byte_cnt;
  logic        frame_err;
  logic        overrun;

  int testsRun  = 0;
  int failCount = 0;
  int frameErrCount = 0;
  int overrunCount  = 0;
  int validRiseCount = 0;
  logic prevValid = 1'b0;

  int baseFe, baseOv, baseVr;

  uart_rx_word_packer #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(4)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .data_out(data_out), .valid(valid),
    .ready(ready), .byte_cnt(byte_cnt), .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and edge counters used as the reference for the one-cycle outputs.
  always @(negedge clk) begin
    prevValid <= valid;
    if (frame_err) frameErrCount <= frameErrCount + 1;
    if (overrun) overrunCount <= overrunCount + 1;
    if (valid && !prevValid) validRiseCount <= validRiseCount + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic bitTime();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic markCounts();
    baseFe = frameErrCount;
    baseOv = overrunCount;
    baseVr = validRiseCount;
  endtask

  // One full frame followed by one idle bit period; stopBit=0 forces a framing error.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    @(negedge clk);
    uart_rx = 1'b0;
    bitTime();
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      bitTime();
    end
    uart_rx = stopBit;
    bitTime();
    uart_rx = 1'b1;
    bitTime();
  endtask

  initial begin
    logic [7:0] partial;

    rst = 1'b1;
    uart_rx = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_data_out", data_out, 32'h0);
    checkOutput("reset_valid", {31'b0, valid}, 32'h0);
    checkOutput("reset_byte_cnt", {30'b0, byte_cnt}, 32'h0);
    checkOutput("reset_frame_err", {31'b0, frame_err}, 32'h0);
    checkOutput("reset_overrun", {31'b0, overrun}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bitTime();

    $display("[TB] step 1: four bytes with ready high");
    ready = 1'b1;
    markCounts();
    applyStimulus(8'h11, 1'b1); settle();
    checkOutput("t1_byte_cnt_1", {30'b0, byte_cnt}, 32'd1);
    applyStimulus(8'h22, 1'b1); settle();
    checkOutput("t1_byte_cnt_2", {30'b0, byte_cnt}, 32'd2);
    applyStimulus(8'h33, 1'b1); settle();
    checkOutput("t1_byte_cnt_3", {30'b0, byte_cnt}, 32'd3);
    applyStimulus(8'h44, 1'b1); settle();
    checkOutput("t1_byte_cnt_0", {30'b0, byte_cnt}, 32'd0);
    checkOutput("t1_data_out", data_out, 32'h44332211);
    checkOutput("t1_valid_pulses", 32'(validRiseCount - baseVr), 32'd1);
    checkOutput("t1_valid_consumed", {31'b0, valid}, 32'h0);
    checkOutput("t1_frame_err", 32'(frameErrCount - baseFe), 32'd0);
    checkOutput("t1_overrun", 32'(overrunCount - baseOv), 32'd0);

    $display("[TB] step 2: eight bytes with ready low");
    ready = 1'b0;
    markCounts();
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1);
    settle();
    checkOutput("t2_first_valid", {31'b0, valid}, 32'h1);
    checkOutput("t2_first_data", data_out, 32'h04030201);
    for (int i = 5; i <= 8; i++) applyStimulus(8'(i), 1'b1);
    settle();
    checkOutput("t2_overrun_pulses", 32'(overrunCount - baseOv), 32'd1);
    checkOutput("t2_data_held", data_out, 32'h04030201);
    checkOutput("t2_valid_held", {31'b0, valid}, 32'h1);
    checkOutput("t2_byte_cnt", {30'b0, byte_cnt}, 32'd0);
    checkOutput("t2_valid_rises", 32'(validRiseCount - baseVr), 32'd1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t2_valid_drop", {31'b0, valid}, 32'h0);

    $display("[TB] step 3: bad stop bit, then a clean word");
    markCounts();
    applyStimulus(8'hA5, 1'b0);
    bitTime();
    settle();
    checkOutput("t3_frame_err_pulses", 32'(frameErrCount - baseFe), 32'd1);
    checkOutput("t3_byte_cnt", {30'b0, byte_cnt}, 32'd0);
    checkOutput("t3_no_valid", 32'(validRiseCount - baseVr), 32'd0);
    applyStimulus(8'hDE, 1'b1);
    applyStimulus(8'hAD, 1'b1);
    applyStimulus(8'hBE, 1'b1);
    applyStimulus(8'hEF, 1'b1);
    settle();
    checkOutput("t3_data_out", data_out, 32'hEFBEADDE);
    checkOutput("t3_frame_err_total", 32'(frameErrCount - baseFe), 32'd1);

    $display("[TB] step 4: short low glitch");
    markCounts();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    settle();
    checkOutput("t4_byte_cnt", {30'b0, byte_cnt}, 32'd0);
    checkOutput("t4_frame_err", 32'(frameErrCount - baseFe), 32'd0);
    checkOutput("t4_no_valid", 32'(validRiseCount - baseVr), 32'd0);
    checkOutput("t4_data_kept", data_out, 32'hEFBEADDE);

    $display("[TB] step 5: partial word timeout");
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h66, 1'b1);
    settle();
    checkOutput("t5_partial_cnt", {30'b0, byte_cnt}, 32'd2);
    repeat (4 * CPB) @(negedge clk);
    settle();
    checkOutput("t5_timeout_cnt", {30'b0, byte_cnt}, 32'd0);
    markCounts();
    for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1'b1);
    settle();
    checkOutput("t5_data_out", data_out, 32'h13121110);
    checkOutput("t5_valid_rises", 32'(validRiseCount - baseVr), 32'd1);

    $display("[TB] step 6: reset during the third byte");
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hBB, 1'b1);
    settle();
    checkOutput("t6_partial_cnt", {30'b0, byte_cnt}, 32'd2);
    partial = 8'hC7;
    @(negedge clk);
    uart_rx = 1'b0;
    bitTime();
    for (int i = 0; i < 4; i++) begin
      uart_rx = partial[i];
      bitTime();
    end
    uart_rx = partial[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_data_out", data_out, 32'h0);
    checkOutput("t6_rst_valid", {31'b0, valid}, 32'h0);
    checkOutput("t6_rst_byte_cnt", {30'b0, byte_cnt}, 32'd0);
    checkOutput("t6_rst_frame_err", {31'b0, frame_err}, 32'h0);
    checkOutput("t6_rst_overrun", {31'b0, overrun}, 32'h0);
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b0;
    bitTime();
    bitTime();
    markCounts();
    for (int i = 0; i < 4; i++) applyStimulus(8'hC0 + 8'(i), 1'b1);
    settle();
    checkOutput("t6_data_out", data_out, 32'hC3C2C1C0);
    checkOutput("t6_byte_cnt", {30'b0, byte_cnt}, 32'd0);
    checkOutput("t6_frame_err", 32'(frameErrCount - baseFe), 32'd0);
    checkOutput("t6_overrun", 32'(overrunCount - baseOv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
